// File: rtl/lgn_pkg.sv
// rtl/lgn_pkg.sv - shared constants, segment patterns and loader state type for the lgn frame loader
package lgn_pkg;

    localparam int INPUTS      = 784;
    localparam int FRAME_BYTES = INPUTS / 8;

    // Segment patterns, bit order .7654321 (bit 6 = segment 7 ... bit 0 = segment 1).
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7C;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h67;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational seven-segment pattern to class index decoder
// Ports:
//   seg     in  7  segment pattern from lgn uo_out[6:0]
//   digit   out 4  class index 0..9, 4'hF for any unknown pattern
//   invalid out 1  pattern is not one of the ten digit encodings
module seven_segment_decode
    import lgn_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       invalid
);

    always_comb begin
        digit   = 4'hF;
        invalid = 1'b0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/lgn_frame_loader.sv
// rtl/lgn_frame_loader.sv - replays a byte-stream image into lgn and returns the decoded class
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last    pixel byte stream in (first byte lands in lgn x[783:776])
//   lgn_write_enable, lgn_ui_in      shift pulses and data towards lgn
//   lgn_uo_out                       lgn output: [6:0] segments, [7] ~write_enable, [15:8] best value
//   result_valid/result_ready        result handshake
//   result_index/value/err           decoded class, value byte, capture-time error
//   frame_abort                      one-cycle pulse when a short frame is discarded
module lgn_frame_loader
    import lgn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        lgn_write_enable,
    output logic [7:0]  lgn_ui_in,
    input  logic [15:0] lgn_uo_out,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [3:0]  result_index,
    output logic [7:0]  result_value,
    output logic        result_err,
    output logic        frame_abort
);

    localparam int         SW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [6:0] LAST_IDX = 7'(FRAME_BYTES - 1);

    loader_state_t state, state_nxt;
    logic [6:0]    byte_cnt;
    logic [SW-1:0] settle_cnt;
    logic          missing_last;

    logic [3:0] dec_digit;
    logic       dec_invalid;

    logic accept, last_byte, settle_done, handshake;

    // Gated by rst_n so the port reads 0 while reset is held, not just after the first edge.
    assign s_ready     = rst_n && (state == LOAD);
    assign accept      = s_valid && s_ready;
    assign last_byte   = (byte_cnt == LAST_IDX);
    // Count 0 is the cycle of the final write pulse; capture happens once SETTLE_CYCLES idle cycles follow it.
    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES));
    assign handshake   = result_valid && result_ready;

    seven_segment_decode u_decode (
        .seg     (lgn_uo_out[6:0]),
        .digit   (dec_digit),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && last_byte) state_nxt = SETTLE;
            SETTLE:  if (settle_done)         state_nxt = DONE;
            DONE:    if (handshake)           state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt         <= 7'd0;
            settle_cnt       <= '0;
            missing_last     <= 1'b0;
            lgn_write_enable <= 1'b0;
            lgn_ui_in        <= 8'd0;
            frame_abort      <= 1'b0;
            result_valid     <= 1'b0;
            result_index     <= 4'd0;
            result_value     <= 8'd0;
            result_err       <= 1'b0;
        end else begin
            lgn_write_enable <= accept;
            frame_abort      <= accept && s_last && !last_byte;

            if (accept) begin
                lgn_ui_in <= s_data;
                // The 98th byte always completes the frame, so s_last there is not an abort.
                if (last_byte || s_last) byte_cnt <= 7'd0;
                else                     byte_cnt <= byte_cnt + 7'd1;
            end

            if (handshake)                          missing_last <= 1'b0;
            else if (accept && last_byte && !s_last) missing_last <= 1'b1;

            if (state == SETTLE && !settle_done) settle_cnt <= settle_cnt + SW'(1);
            else                                 settle_cnt <= '0;

            if (state == SETTLE && settle_done) begin
                result_valid <= 1'b1;
                result_value <= lgn_uo_out[15:8];
                result_index <= dec_digit;
                result_err   <= missing_last || dec_invalid || !lgn_uo_out[7];
            end else if (handshake) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lgn_frame_loader.sv
// tb/tb_lgn_frame_loader.sv - self-checking bench for lgn_frame_loader with a result scoreboard
module tb_lgn_frame_loader;

    localparam int SETTLE = 2;
    localparam int NBYTES = 98;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_last;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        lgn_write_enable;
    logic [7:0]  lgn_ui_in;
    logic [15:0] lgn_uo_out;
    logic        result_valid, result_ready;
    logic [3:0]  result_index;
    logic [7:0]  result_value;
    logic        result_err, frame_abort;

    logic [7:0] uo_hi;
    logic [6:0] uo_seg;
    logic       uo_force7;

    logic [6:0] dec_in;
    logic [3:0] dec_digit;
    logic       dec_invalid;

    typedef struct {
        logic [3:0] index;
        logic [7:0] value;
        logic       err;
    } result_t;

    logic [7:0] exp_q[$];
    result_t    res_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = 0;
    int model_cnt = 0;
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    assign lgn_uo_out = {uo_hi, uo_force7 ? 1'b0 : ~lgn_write_enable, uo_seg};

    lgn_frame_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .lgn_write_enable (lgn_write_enable),
        .lgn_ui_in        (lgn_ui_in),
        .lgn_uo_out       (lgn_uo_out),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_index     (result_index),
        .result_value     (result_value),
        .result_err       (result_err),
        .frame_abort      (frame_abort)
    );

    seven_segment_decode u_dec (
        .seg     (dec_in),
        .digit   (dec_digit),
        .invalid (dec_invalid)
    );

    function automatic logic [3:0] ref_dec(input logic [6:0] s);
        case (s)
            7'h3F: return 4'd0;
            7'h06: return 4'd1;
            7'h5B: return 4'd2;
            7'h4F: return 4'd3;
            7'h66: return 4'd4;
            7'h6D: return 4'd5;
            7'h7C: return 4'd6;
            7'h07: return 4'd7;
            7'h7F: return 4'd8;
            7'h67: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the inputs about to be sampled, then check after the edge.
    task automatic tick();
        logic    acc, abort_exp, complete;
        result_t r, e;
        acc       = s_valid && s_ready;
        abort_exp = 1'b0;
        complete  = 1'b0;
        if (acc) begin
            exp_q.push_back(s_data);
            if (model_cnt == NBYTES - 1) begin
                complete  = 1'b1;
                model_cnt = 0;
                r.index   = ref_dec(uo_seg);
                r.value   = uo_hi;
                r.err     = !s_last || (r.index == 4'hF) || uo_force7;
                res_q.push_back(r);
            end else if (s_last) begin
                abort_exp = 1'b1;
                model_cnt = 0;
            end else begin
                model_cnt++;
            end
        end
        if (result_valid && result_ready) begin
            if (res_q.size() == 0) begin
                chk("result_unexpected", 1, 0);
            end else begin
                e = res_q.pop_front();
                chk("result_index", result_index, e.index);
                chk("result_value", result_value, e.value);
                chk("result_err", result_err, e.err);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (complete) done_cyc = cyc;
        chk("write_enable", lgn_write_enable, acc);
        if (lgn_write_enable && exp_q.size() > 0) chk("ui_in", lgn_ui_in, exp_q.pop_front());
        chk("frame_abort", frame_abort, abort_exp);
        if (result_valid && !rv_prev) begin
            if (res_q.size() == 0) chk("result_unexpected", 1, 0);
            else                   chk("result_latency", cyc - done_cyc, 1 + SETTLE);
        end
        rv_prev = result_valid;
    endtask

    task automatic send_frame(input int n, input logic last_final, input logic gaps);
        int budget;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    tick();
                end
            end
            s_valid = 1'b1;
            s_data  = 8'(i);
            s_last  = (i == n - 1) ? last_final : 1'b0;
            budget  = 0;
            while (s_ready !== 1'b1 && budget < 300) begin
                tick();
                budget++;
            end
            if (budget >= 300) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (res_q.size() > 0 && budget < 300) begin
            tick();
            budget++;
        end
        if (res_q.size() > 0) chk("drain_timeout", res_q.size(), 0);
    endtask

    initial begin
        logic [3:0] snap_idx;
        logic [7:0] snap_val;
        logic       snap_err;
        int         b;

        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0; result_ready = 1'b0;
        uo_hi = 8'h5A; uo_seg = 7'h6D; uo_force7 = 1'b0; dec_in = 7'd0;

        // Decoder on its own, every pattern.
        for (int p = 0; p < 128; p++) begin
            dec_in = 7'(p);
            #1;
            chk("dec_digit", dec_digit, ref_dec(7'(p)));
            chk("dec_invalid", dec_invalid, ref_dec(7'(p)) == 4'hF);
        end

        // Reset state.
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_we", lgn_write_enable, 0);
        chk("rst_ui_in", lgn_ui_in, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_index", result_index, 0);
        chk("rst_result_value", result_value, 0);
        chk("rst_result_err", result_err, 0);
        chk("rst_frame_abort", frame_abort, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("s_ready_after_release", s_ready, 1);

        // Back-to-back frame, result held with result_ready low for 10 cycles.
        send_frame(NBYTES, 1'b1, 1'b0);
        b = 0;
        while (!result_valid && b < 20) begin tick(); b++; end
        chk("result_valid_seen", result_valid, 1);
        snap_idx = result_index; snap_val = result_value; snap_err = result_err;
        chk("t1_index", snap_idx, 5);
        chk("t1_value", snap_val, 8'h5A);
        chk("t1_err", snap_err, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold_valid", result_valid, 1);
            chk("hold_index", result_index, snap_idx);
            chk("hold_value", result_value, snap_val);
            chk("hold_err", result_err, snap_err);
            chk("hold_s_ready", s_ready, 0);
        end
        result_ready = 1'b1;
        tick();
        chk("post_hs_valid", result_valid, 0);
        chk("post_hs_s_ready", s_ready, 1);

        // Same frame with random gaps in s_valid.
        send_frame(NBYTES, 1'b1, 1'b1);
        drain();

        // Short frame aborted, then a full frame completes cleanly.
        send_frame(50, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_no_result", result_valid, 0);
        end
        uo_hi = 8'h33; uo_seg = 7'h4F;
        send_frame(NBYTES, 1'b1, 1'b0);
        drain();

        // Error cases: missing s_last, invalid pattern, uo_out[7] low.
        uo_hi = 8'h81; uo_seg = 7'h7F;
        send_frame(NBYTES, 1'b0, 1'b0);
        drain();
        uo_seg = 7'h00;
        send_frame(NBYTES, 1'b1, 1'b0);
        drain();
        uo_seg = 7'h06; uo_force7 = 1'b1;
        send_frame(NBYTES, 1'b1, 1'b0);
        drain();
        uo_force7 = 1'b0;

        // Asynchronous reset in the middle of a frame.
        send_frame(40, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", lgn_write_enable, 0);
        chk("mid_rst_ui_in", lgn_ui_in, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_result_valid", result_valid, 0);
        chk("mid_rst_frame_abort", frame_abort, 0);
        exp_q.delete();
        model_cnt = 0;
        rv_prev   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_s_ready", s_ready, 1);
        uo_hi = 8'hC4; uo_seg = 7'h67;
        send_frame(NBYTES, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < 4; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
